// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART byte-command front end; fills input/weight buffers, streams an accelerator row LSB-first, reports sticky errors (ack byte per write when UART_CMD_CTRL_ACK_EN).
// Latency: a byte toggle is decoded on the next clock edge; a row read starts transmitting two cycles after its opcode.
// Backpressure: transmit strobes wait for isBusy low; received bytes are never stalled (discarded while reading or transmitting).
module uart_cmd_ctrl #(
    parameter int BITWIDTH  = 8,
    parameter int IN_BYTES  = 32,
    parameter int WT_BYTES  = 128,
    parameter int OUT_BYTES = 24,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BITWIDTH-1:0]    dataIn,
    input  logic                   isNewData,
    input  logic                   isBusy,
    output logic [BITWIDTH-1:0]    dataOut,
    output logic                   doTransmit,
    output logic [IN_BYTES*8-1:0]  din,
    output logic [WT_BYTES*8-1:0]  wtin,
    output logic                   isNewDin,
    output logic                   isNewWtin,
    output logic [ADDR_W-1:0]      addrDout,
    input  logic [OUT_BYTES*8-1:0] dout,
    output logic [1:0]             err,
    output logic [2:0]             state_tap
);

    localparam int IN_W  = IN_BYTES * 8;
    localparam int WT_W  = WT_BYTES * 8;
    localparam int OUT_W = OUT_BYTES * 8;
    localparam int MAX_B = (IN_BYTES > WT_BYTES) ? IN_BYTES : WT_BYTES;
    localparam int CNT_W = $clog2(MAX_B + 1);
    localparam int SNT_W = $clog2(OUT_BYTES + 1);
    localparam int IDL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_IN    = 3'd1,
        WR_WT    = 3'd2,
        RD_LATCH = 3'd3,
        RD_SEND  = 3'd4,
        RD_WAIT  = 3'd5,
        TX_ONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        K_READ   = 2'd0,
        K_STATUS = 2'd1,
        K_ACK_IN = 2'd2,
        K_ACK_WT = 2'd3
    } kind_t;

`ifdef UART_CMD_CTRL_ACK_EN
    localparam state_t WR_DONE = TX_ONE;
`else
    localparam state_t WR_DONE = IDLE;
`endif

    state_t               state, state_nxt;
    kind_t                kind;
    logic                 prev_new;
    logic [CNT_W-1:0]     byte_cnt;
    logic [IDL_W-1:0]     idle_cnt;
    logic [SNT_W-1:0]     sent_cnt;
    logic [1:0]           wait_cnt;
    logic [OUT_W-1:0]     shift;
    logic [BITWIDTH-1:0]  tx_byte;

    logic       new_byte, in_done, wt_done, timed_out, send_last, wait_over;
    logic [2:0] opcode;

    assign new_byte  = (isNewData != prev_new);
    assign opcode    = dataIn[2:0];
    assign in_done   = (state == WR_IN) && new_byte && (byte_cnt == CNT_W'(IN_BYTES - 1));
    assign wt_done   = (state == WR_WT) && new_byte && (byte_cnt == CNT_W'(WT_BYTES - 1));
    assign timed_out = ((state == WR_IN) || (state == WR_WT)) && !new_byte
                       && (idle_cnt == IDL_W'(TIMEOUT - 1));
    assign send_last = (kind == K_READ) ? (sent_cnt == SNT_W'(OUT_BYTES)) : (sent_cnt == SNT_W'(1));
    assign wait_over = (wait_cnt == 2'd2);
    assign state_tap = state;

    // Single-byte payloads share the row-read send path through the shift register.
    always_comb begin
        tx_byte = {{(BITWIDTH-2){1'b0}}, err};
        if (kind == K_ACK_IN) begin
            tx_byte = BITWIDTH'(8'hA5);
        end else if (kind == K_ACK_WT) begin
            tx_byte = BITWIDTH'(8'h5A);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (new_byte) begin
                    case (opcode)
                        3'd1:    state_nxt = RD_LATCH;
                        3'd2:    state_nxt = WR_IN;
                        3'd3:    state_nxt = WR_WT;
                        3'd4:    state_nxt = TX_ONE;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            WR_IN: begin
                if (in_done) begin
                    state_nxt = WR_DONE;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            WR_WT: begin
                if (wt_done) begin
                    state_nxt = WR_DONE;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            RD_LATCH: state_nxt = RD_SEND;
            TX_ONE:   state_nxt = RD_SEND;
            RD_SEND: begin
                if (!isBusy) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_over && !isBusy) begin
                    state_nxt = send_last ? IDLE : RD_SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_new   <= 1'b0;
            kind       <= K_READ;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            sent_cnt   <= '0;
            wait_cnt   <= '0;
            shift      <= '0;
            dataOut    <= '0;
            doTransmit <= 1'b0;
            din        <= '0;
            wtin       <= '0;
            isNewDin   <= 1'b0;
            isNewWtin  <= 1'b0;
            addrDout   <= '0;
            err        <= 2'b00;
        end else begin
            doTransmit <= 1'b0;
            prev_new   <= isNewData;
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                    sent_cnt <= '0;
                    if (new_byte) begin
                        case (opcode)
                            3'd1: begin
                                addrDout <= dataIn[ADDR_W+2:3];
                                kind     <= K_READ;
                            end
                            3'd2, 3'd3: ;
                            3'd4:    kind   <= K_STATUS;
                            default: err[1] <= 1'b1;
                        endcase
                    end
                end
                WR_IN, WR_WT: begin
                    if (new_byte) begin
                        idle_cnt <= '0;
                        if (state == WR_IN) begin
                            din <= {din[IN_W-9:0], dataIn[7:0]};
                        end else begin
                            wtin <= {wtin[WT_W-9:0], dataIn[7:0]};
                        end
                        if (in_done) begin
                            isNewDin <= ~isNewDin;
                            byte_cnt <= '0;
                            kind     <= K_ACK_IN;
                        end else if (wt_done) begin
                            isNewWtin <= ~isNewWtin;
                            byte_cnt  <= '0;
                            kind      <= K_ACK_WT;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timed_out) begin
                        err[0]   <= 1'b1;
                        idle_cnt <= '0;
                        byte_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                RD_LATCH: shift <= dout;
                TX_ONE:   shift <= OUT_W'(tx_byte);
                RD_SEND: begin
                    if (!isBusy) begin
                        dataOut    <= shift[BITWIDTH-1:0];
                        doTransmit <= 1'b1;
                        shift      <= shift >> 8;
                        sent_cnt   <= sent_cnt + 1'b1;
                        wait_cnt   <= '0;
                    end
                end
                RD_WAIT: begin
                    // The transmitter may take two cycles to raise isBusy after a strobe.
                    if (!wait_over) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (!isBusy && send_last) begin
                        sent_cnt <= '0;
                        if (kind == K_STATUS) begin
                            err <= 2'b00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: random bytes, gaps and row data checked against a byte-history model.
module tb_uart_cmd_ctrl;

    localparam int BW   = 8;
    localparam int INB  = 32;
    localparam int WTB  = 128;
    localparam int OUTB = 24;
    localparam int AW   = 4;
    localparam int TO   = 300;

`ifdef UART_CMD_CTRL_ACK_EN
    localparam int ACKS = 1;
`else
    localparam int ACKS = 0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic [BW-1:0]        dataIn;
    logic                 isNewData;
    logic                 isBusy;
    logic [BW-1:0]        dataOut;
    logic                 doTransmit;
    logic [INB*8-1:0]     din;
    logic [WTB*8-1:0]     wtin;
    logic                 isNewDin;
    logic                 isNewWtin;
    logic [AW-1:0]        addrDout;
    logic [OUTB*8-1:0]    dout;
    logic [1:0]           err;
    logic [2:0]           state_tap;

    uart_cmd_ctrl #(
        .BITWIDTH(BW), .IN_BYTES(INB), .WT_BYTES(WTB),
        .OUT_BYTES(OUTB), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .isNewData(isNewData),
        .isBusy(isBusy), .dataOut(dataOut), .doTransmit(doTransmit), .din(din),
        .wtin(wtin), .isNewDin(isNewDin), .isNewWtin(isNewWtin), .addrDout(addrDout),
        .dout(dout), .err(err), .state_tap(state_tap)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tx_q[$];
    logic [7:0] din_hist[$];
    logic [7:0] wt_hist[$];
    int din_tog = 0;
    int wt_tog = 0;
    int busy_viol = 0;
    int busy_left = 0;
    logic prev_din_v = 1'b0;
    logic prev_wt_v = 1'b0;

    // Transmitter model: busy for a random stretch after each strobe; also logs strobes and buffer toggles.
    initial begin
        isBusy = 1'b0;
        forever begin
            @(negedge clock);
            if (isNewDin !== prev_din_v) din_tog++;
            if (isNewWtin !== prev_wt_v) wt_tog++;
            prev_din_v = isNewDin;
            prev_wt_v  = isNewWtin;
            if (doTransmit === 1'b1) begin
                tx_q.push_back(dataOut);
                if (isBusy) busy_viol++;
                busy_left = $urandom_range(3, 8);
            end else if (busy_left > 0) begin
                busy_left--;
            end
            isBusy = (busy_left > 0);
        end
    end

    // Buffers hold the most recent bytes written, newest in the low byte.
    function automatic logic [INB*8-1:0] exp_din();
        logic [INB*8-1:0] v = '0;
        for (int j = 0; j < INB && j < din_hist.size(); j++)
            v[8*j +: 8] = din_hist[din_hist.size()-1-j];
        return v;
    endfunction

    function automatic logic [WTB*8-1:0] exp_wtin();
        logic [WTB*8-1:0] v = '0;
        for (int j = 0; j < WTB && j < wt_hist.size(); j++)
            v[8*j +: 8] = wt_hist[wt_hist.size()-1-j];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        dataIn    = b;
        isNewData = ~isNewData;
        @(negedge clock);
        repeat (gap) @(negedge clock);
    endtask

    task automatic write_seq(input bit wt, input logic [7:0] bytes[$], input int gap_max);
        send_byte(wt ? 8'h03 : 8'h02, $urandom_range(0, gap_max));
        foreach (bytes[i]) begin
            send_byte(bytes[i], $urandom_range(0, gap_max));
            if (wt) wt_hist.push_back(bytes[i]);
            else    din_hist.push_back(bytes[i]);
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx_q.size() >= n && state_tap == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; isNewData = 1'b0; dataIn = '0; dout = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({dataOut, doTransmit, isNewDin, isNewWtin, addrDout, err, state_tap} !== '0) begin
            n_bad++; $display("FAIL reset_ctrl: got %h want 0", {dataOut, doTransmit, isNewDin, isNewWtin, addrDout, err, state_tap});
        end
        n_cmp++;
        if (din !== '0) begin n_bad++; $display("FAIL reset_din: got %h want 0", din); end
        n_cmp++;
        if (wtin !== '0) begin n_bad++; $display("FAIL reset_wtin: got %h want 0", wtin); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (state_tap !== 3'd0 || doTransmit !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: state %0d strobe %b want 0 0", state_tap, doTransmit);
        end
        din_tog = 0; wt_tog = 0; tx_q.delete();
    endtask

    task automatic test_write_in();
        logic [7:0] b[$];
        bit ok;
        int t0 = din_tog, w0 = wt_tog;
        tx_q.delete();
        for (int i = 0; i < INB; i++) b.push_back(8'(i));
        write_seq(1'b0, b, 2);
        wait_tx(ACKS, 300, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_in_done: timed out, state %0d", state_tap); end
        n_cmp++;
        if (din_tog - t0 !== 1 || wt_tog - w0 !== 0) begin
            n_bad++; $display("FAIL wr_in_toggle: din %0d wt %0d want 1 0", din_tog - t0, wt_tog - w0);
        end
        n_cmp++;
        if (din[7:0] !== 8'h1F || din[255:248] !== 8'h00) begin
            n_bad++; $display("FAIL wr_in_ends: low %h high %h want 1f 00", din[7:0], din[255:248]);
        end
        n_cmp++;
        if (din !== exp_din()) begin n_bad++; $display("FAIL wr_in_din: got %h want %h", din, exp_din()); end
        n_cmp++;
        if (state_tap !== 3'd0 || tx_q.size() !== ACKS) begin
            n_bad++; $display("FAIL wr_in_end: state %0d acks %0d want 0 %0d", state_tap, tx_q.size(), ACKS);
        end
        foreach (tx_q[i]) begin
            n_cmp++;
            if (tx_q[i] !== 8'hA5) begin n_bad++; $display("FAIL wr_in_ack: got %h want a5", tx_q[i]); end
        end
    endtask

    task automatic test_write_wt();
        logic [7:0] b[$];
        bit ok;
        int t0 = din_tog, w0 = wt_tog;
        tx_q.delete();
        for (int i = 0; i < WTB; i++) b.push_back(8'hFF);
        write_seq(1'b1, b, 1);
        wait_tx(ACKS, 300, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_wt_done: timed out, state %0d", state_tap); end
        n_cmp++;
        if (wt_tog - w0 !== 1 || din_tog - t0 !== 0) begin
            n_bad++; $display("FAIL wr_wt_toggle: wt %0d din %0d want 1 0", wt_tog - w0, din_tog - t0);
        end
        n_cmp++;
        if (wtin !== {WTB*8{1'b1}}) begin n_bad++; $display("FAIL wr_wt_ones: got %h", wtin); end
        n_cmp++;
        if (tx_q.size() !== ACKS) begin n_bad++; $display("FAIL wr_wt_acks: got %0d want %0d", tx_q.size(), ACKS); end
        foreach (tx_q[i]) begin
            n_cmp++;
            if (tx_q[i] !== 8'h5A) begin n_bad++; $display("FAIL wr_wt_ack: got %h want 5a", tx_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] b[$];
            bit ok;
            bit wt = r[0];
            int t0 = din_tog, w0 = wt_tog;
            tx_q.delete();
            for (int i = 0; i < (wt ? WTB : INB) + 3; i++) b.push_back(8'($urandom));
            // The 3 extra bytes after completion are decoded as opcodes only without an ack phase.
            b = b[0 : (wt ? WTB : INB) - 1];
            write_seq(wt, b, 0);
            wait_tx(ACKS, 300, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL b2b_done%0d: timed out", r); end
            n_cmp++;
            if (din !== exp_din() || wtin !== exp_wtin()) begin
                n_bad++; $display("FAIL b2b_buf%0d: din %h want %h", r, din, exp_din());
            end
            n_cmp++;
            if ((din_tog - t0) + (wt_tog - w0) !== 1) begin
                n_bad++; $display("FAIL b2b_toggle%0d: got %0d want 1", r, (din_tog - t0) + (wt_tog - w0));
            end
        end
    endtask

    task automatic test_read();
        for (int r = 0; r < 3; r++) begin
            logic [OUTB*8-1:0] row;
            logic [AW-1:0] addr;
            logic [7:0] cmd;
            bit ok;
            int t0 = din_tog;
            if (r == 0) begin
                addr = 4'd5; cmd = 8'h29;
                for (int i = 0; i < OUTB; i++) row[8*i +: 8] = 8'(i);
            end else begin
                addr = AW'($urandom);
                cmd = {1'($urandom), addr, 3'b001};
                for (int i = 0; i < OUTB; i++) row[8*i +: 8] = 8'($urandom);
            end
            dout = row;
            tx_q.delete();
            busy_viol = 0;
            send_byte(cmd, 0);
            repeat (6) @(negedge clock);
            send_byte(8'h02, 0);
            wait_tx(OUTB, 2000, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rd_done%0d: timed out, sent %0d", r, tx_q.size()); end
            n_cmp++;
            if (addrDout !== addr) begin n_bad++; $display("FAIL rd_addr%0d: got %0d want %0d", r, addrDout, addr); end
            n_cmp++;
            if (tx_q.size() !== OUTB) begin n_bad++; $display("FAIL rd_count%0d: got %0d want %0d", r, tx_q.size(), OUTB); end
            foreach (tx_q[i]) begin
                n_cmp++;
                if (i < OUTB && tx_q[i] !== row[8*i +: 8]) begin
                    n_bad++; $display("FAIL rd_byte%0d_%0d: got %h want %h", r, i, tx_q[i], row[8*i +: 8]);
                end
            end
            n_cmp++;
            if (busy_viol !== 0) begin n_bad++; $display("FAIL rd_busy%0d: %0d strobes while busy, want 0", r, busy_viol); end
            repeat (4) @(negedge clock);
            n_cmp++;
            if (state_tap !== 3'd0 || din_tog !== t0 || dataOut !== row[8*(OUTB-1) +: 8]) begin
                n_bad++; $display("FAIL rd_after%0d: state %0d dataOut %h want 0 %h", r, state_tap, dataOut, row[8*(OUTB-1) +: 8]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t0 = din_tog;
        send_byte(8'h02, 0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] v = 8'($urandom);
            send_byte(v, (i == 9) ? 0 : 1);
            din_hist.push_back(v);
        end
        repeat (TO - 1) @(negedge clock);
        n_cmp++;
        if (state_tap !== 3'd1 || err !== 2'b00) begin
            n_bad++; $display("FAIL to_early: state %0d err %b want 1 00", state_tap, err);
        end
        @(negedge clock);
        n_cmp++;
        if (state_tap !== 3'd0 || err !== 2'b01) begin
            n_bad++; $display("FAIL to_abort: state %0d err %b want 0 01", state_tap, err);
        end
        n_cmp++;
        if (din_tog !== t0 || din !== exp_din()) begin
            n_bad++; $display("FAIL to_din: toggles %0d din %h want 0 %h", din_tog - t0, din, exp_din());
        end
        tx_q.delete();
        send_byte(8'h04, 0);
        wait_tx(1, 200, ok);
        n_cmp++;
        if (!ok || tx_q.size() !== 1 || tx_q[0] !== 8'h01) begin
            n_bad++; $display("FAIL to_status: got %0d bytes first %h want 1 01", tx_q.size(), tx_q[0]);
        end
        n_cmp++;
        if (err !== 2'b00) begin n_bad++; $display("FAIL to_clear: err %b want 00", err); end
    endtask

    task automatic test_bad_opcode();
        bit ok;
        logic [2:0] bad_ops[4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            logic [7:0] op = (i == 0) ? 8'h07 : {5'($urandom), bad_ops[$urandom_range(0, 3)]};
            send_byte(op, 1);
            n_cmp++;
            if (err !== 2'b10 || state_tap !== 3'd0) begin
                n_bad++; $display("FAIL bad_op%0d (%h): err %b state %0d want 10 0", i, op, err, state_tap);
            end
        end
        tx_q.delete();
        send_byte(8'h04, 0);
        wait_tx(1, 200, ok);
        n_cmp++;
        if (!ok || tx_q.size() !== 1 || tx_q[0] !== 8'h02) begin
            n_bad++; $display("FAIL bad_status: got %0d bytes first %h want 1 02", tx_q.size(), tx_q[0]);
        end
        n_cmp++;
        if (err !== 2'b00) begin n_bad++; $display("FAIL bad_clear: err %b want 00", err); end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int n0;
        int strobes = 0;
        for (int i = 0; i < OUTB; i++) dout[8*i +: 8] = 8'($urandom);
        tx_q.delete();
        send_byte({1'b0, 4'($urandom), 3'b001}, 0);
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            ok = (tx_q.size() >= 3);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_rd_start: %0d bytes want 3", tx_q.size()); end
        reset = 1'b1; isNewData = 1'b0; dataIn = '0;
        @(negedge clock);
        n0 = tx_q.size();
        din_hist.delete(); wt_hist.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (doTransmit !== 1'b0) strobes++;
        end
        n_cmp++;
        if (strobes !== 0 || tx_q.size() !== n0) begin
            n_bad++; $display("FAIL rst_rd_strobe: %0d strobes after reset want 0", strobes);
        end
        n_cmp++;
        if ({dataOut, isNewDin, isNewWtin, addrDout, err, state_tap} !== '0 || din !== '0 || wtin !== '0) begin
            n_bad++; $display("FAIL rst_rd_outs: got %h want 0", {dataOut, isNewDin, isNewWtin, addrDout, err, state_tap});
        end
        send_byte(8'h03, 0);
        repeat (5) send_byte(8'($urandom), 1);
        reset = 1'b1; isNewData = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (wtin !== '0 || isNewWtin !== 1'b0 || state_tap !== 3'd0) begin
            n_bad++; $display("FAIL rst_wr: wtin %h valid %b state %0d want 0 0 0", wtin[63:0], isNewWtin, state_tap);
        end
    endtask

    initial begin
        test_reset();
        test_write_in();
        test_write_wt();
        test_back_to_back();
        test_read();
        test_timeout();
        test_bad_opcode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): BITWIDTH, 8, UART byte width; IN_BYTES, 32, input-buffer write length; WT_BYTES, 128, weight-buffer write length; OUT_BYTES, 24, read-back length; ADDR_W, 4, output-row address width; TIMEOUT, 65535, inter-byte idle cycles before write abort.
REQ-002 SHALL have ports (name direction width meaning): clock in 1 sole clock; reset in 1 synchronous active-high reset.
REQ-003 dataIn in BITWIDTH received byte; isNewData in 1 toggles once per received byte; isBusy in 1 UART transmitter busy.
REQ-004 dataOut out BITWIDTH byte to transmit; doTransmit out 1 one-cycle transmit strobe.
REQ-005 din out IN_BYTES*8 input buffer; wtin out WT_BYTES*8 weight buffer; isNewDin out 1 and isNewWtin out 1, each toggles on a completed write.
REQ-006 addrDout out ADDR_W read row address; dout in OUT_BYTES*8 accelerator row data; err out 2 sticky error flags; state_tap out 3 current FSM state encoding.

Function
REQ-007 SHALL detect a new byte when isNewData differs from its registered previous value; every detected byte updates the previous value in all states.
REQ-008 SHALL use FSM states IDLE=0, WR_IN=1, WR_WT=2, RD_LATCH=3, RD_SEND=4, RD_WAIT=5, TX_ONE=6; state_tap = state.
REQ-009 In IDLE, new byte opcode dataIn[2:0]: 1 -> RD_LATCH with addrDout = dataIn[ADDR_W+2:3]; 2 -> WR_IN; 3 -> WR_WT; 4 -> TX_ONE (status); other -> stay IDLE, set err[1].
REQ-010 WR_IN/WR_WT: each new byte shifts in at LSB end ({buf, dataIn}), counter increments; on the edge storing byte IN_BYTES (resp. WT_BYTES) SHALL toggle isNewDin (resp. isNewWtin), clear counter, leave state.
REQ-011 In write states an idle counter SHALL reset on each byte; reaching TIMEOUT SHALL set err[0], clear counter, return IDLE, no buffer-valid toggle; partially shifted buffer retained.
REQ-012 RD_LATCH SHALL register dout into a shift register one cycle after opcode decode, then enter RD_SEND.
REQ-013 RD_SEND: when isBusy==0, drive dataOut = shift[7:0], pulse doTransmit one cycle, shift right 8, go RD_WAIT.
REQ-014 RD_WAIT: ignore isBusy for 2 cycles, then on isBusy==0 return RD_SEND, or IDLE after OUT_BYTES bytes sent; bytes LSB-first.
REQ-015 Bytes detected in RD_* or TX_ONE SHALL be discarded, not decoded.
REQ-016 TX_ONE (status): send byte {4'b0, 2'b00, err} with RD_SEND/RD_WAIT timing, then clear err and return IDLE; an error raised in that same cycle SHALL remain set.
REQ-017 doTransmit SHALL be low in all states except the single strobe cycle; dataOut holds last value between strobes.
REQ-018 A byte detected in the cycle a write completes SHALL be counted as the last byte only; the next toggle is decoded in IDLE.

Reset
REQ-019 On reset: state IDLE, counters 0, previous isNewData 0, dataOut 0, doTransmit 0, din 0, wtin 0, isNewDin 0, isNewWtin 0, addrDout 0, err 0, shift register 0.
REQ-020 Reset mid-write or mid-read SHALL abort immediately with no buffer-valid toggle and no further strobe.

Configuration
REQ-021 Macro UART_CMD_CTRL_ACK_EN defined: after a completed write, enter TX_ONE and transmit 0xA5 (input) or 0x5A (weight) before IDLE; undefined: return to IDLE directly, no ack byte.

Verification
REQ-022 Bytes 0x02 then 32 bytes 0x00..0x1F -> isNewDin toggles once, din[7:0]=0x1F, din[255:248]=0x00, state_tap=0.
REQ-023 Byte 0x03 then 128 bytes 0xFF -> isNewWtin toggles, wtin all ones; with ACK_EN one strobe dataOut=0x5A.
REQ-024 Byte 0x29 (addr 5), dout=0x17..00 byte pattern, isBusy low 2 cycles after each strobe -> addrDout=5, 24 strobes with dataOut 0x00,0x01..0x17.
REQ-025 Byte 0x02, 10 bytes, then silence TIMEOUT cycles -> err=2'b01, no isNewDin toggle, state IDLE; then 0x04 -> strobe dataOut=0x01, err=0.
REQ-026 Byte 0x07 -> err[1]=1, state IDLE; reset asserted during read after byte 3 -> doTransmit stays 0, all outputs at reset values.
